imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: parses a length-prefixed, XOR-checksummed
// stream of little-endian 32-bit words, writes them to imem and releases the core.
module imem_loader #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    output logic          rx_ready,
    input  logic          reload,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic          core_reset,
    output logic          done,
    output logic          error
);

    typedef enum logic [2:0] {
        LEN0 = 3'd0,
        LEN1 = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        RUN  = 3'd4,
        ERR  = 3'd5
    } state_t;

    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    state_t        state_r;
    logic [7:0]    len_lo_r;
    logic [AW-1:0] last_idx_r;
    logic [AW-1:0] word_idx_r;
    logic [1:0]    byte_cnt_r;
    logic [7:0]    xor_r;
    logic [23:0]   word_buf_r;

    logic          accept_s;
    logic [15:0]   len_s;
    logic          len_bad_s;
    logic [AW-1:0] last_idx_s;
    logic          last_word_s;

    function automatic logic [7:0] xor_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    // Handshake and length decode for the byte currently on rx_data.
    always_comb begin
        accept_s    = rx_valid && rx_ready;
        len_s       = {rx_data, len_lo_r};
        len_bad_s   = (len_s == 16'd0) || ({1'b0, len_s} > DEPTH_W);
        last_idx_s  = AW'(len_s - 16'd1);
        last_word_s = (word_idx_r == last_idx_r);
    end

    // Loader FSM; every output is registered and set together with the state it belongs to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= LEN0;
            len_lo_r   <= 8'h00;
            last_idx_r <= '0;
            word_idx_r <= '0;
            byte_cnt_r <= 2'd0;
            xor_r      <= 8'h00;
            word_buf_r <= 24'h000000;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'h0000_0000;
            rx_ready   <= 1'b1;
            core_reset <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (state_r)
                LEN0: begin
                    if (accept_s) begin
                        len_lo_r <= rx_data;
                        state_r  <= LEN1;
                    end
                end
                LEN1: begin
                    if (accept_s) begin
                        last_idx_r <= last_idx_s;
                        if (len_bad_s) begin
                            state_r  <= ERR;
                            error    <= 1'b1;
                            rx_ready <= 1'b0;
                        end else begin
                            state_r <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept_s) begin
                        xor_r      <= xor_fold(xor_r, rx_data);
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                        case (byte_cnt_r)
                            2'd0: word_buf_r[7:0]   <= rx_data;
                            2'd1: word_buf_r[15:8]  <= rx_data;
                            2'd2: word_buf_r[23:16] <= rx_data;
                            2'd3: begin
                                imem_we    <= 1'b1;
                                imem_addr  <= word_idx_r;
                                imem_wdata <= {rx_data, word_buf_r};
                                // Holding the index on the last word keeps N==DEPTH from wrapping.
                                if (last_word_s) begin
                                    state_r <= CSUM;
                                end else begin
                                    word_idx_r <= word_idx_r + {{(AW-1){1'b0}}, 1'b1};
                                end
                            end
                            default: word_buf_r <= word_buf_r;
                        endcase
                    end
                end
                CSUM: begin
                    if (accept_s) begin
                        rx_ready <= 1'b0;
                        if (rx_data == xor_r) begin
                            state_r    <= RUN;
                            core_reset <= 1'b0;
                            done       <= 1'b1;
                        end else begin
                            state_r <= ERR;
                            error   <= 1'b1;
                        end
                    end
                end
                RUN, ERR: begin
                    if (reload) begin
                        state_r    <= LEN0;
                        word_idx_r <= '0;
                        byte_cnt_r <= 2'd0;
                        xor_r      <= 8'h00;
                        rx_ready   <= 1'b1;
                        core_reset <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= LEN0;
                    word_idx_r <= '0;
                    byte_cnt_r <= 2'd0;
                    xor_r      <= 8'h00;
                    rx_ready   <= 1'b1;
                    core_reset <= 1'b1;
                    done       <= 1'b0;
                    error      <= 1'b0;
                end
            endcase
        end
    end

endmodule
